// File: rtl/rv32_id_ex_stage.sv
// rtl/rv32_id_ex_stage.sv - RV32I ID/EX stage: operand capture, MEM/WB forwarding, load-use bubbles, flush
// Optional RV32_IDEX_PERF_EN adds a saturating load-use bubble counter on bubble_cnt_o.
module rv32_id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              id_vld_i,
  output logic              id_rdy_o,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              id_srcA_sel_i,
  input  logic              id_srcB_sel_i,
  input  logic [2:0]        id_alu_ctrl_i,
  input  logic              id_reg_wr_i,
  input  logic              id_is_load_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_wr_i,
  input  logic [XLEN-1:0]   mem_rslt_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_wr_i,
  input  logic [XLEN-1:0]   wb_rslt_i,
  input  logic              ex_rdy_i,
  output logic              ex_vld_o,
  output logic [XLEN-1:0]   ex_srcA_o,
  output logic [XLEN-1:0]   ex_srcB_o,
  output logic [XLEN-1:0]   ex_rs2_o,
  output logic [2:0]        ex_alu_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_reg_wr_o,
`ifdef RV32_IDEX_PERF_EN
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              ex_is_load_o
);

  logic              r_vld;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic              r_srcA_sel;
  logic              r_srcB_sel;
  logic [2:0]        r_alu_ctrl;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_wr;
  logic              r_is_load;

  logic              w_adv;
  logic              w_hazard;
  logic              w_rd_match;
  logic              w_mem_hit_rs1;
  logic              w_mem_hit_rs2;
  logic              w_wb_hit_rs1;
  logic              w_wb_hit_rs2;
  logic              w_wb_hit_id_rs1;
  logic              w_wb_hit_id_rs2;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic [XLEN-1:0]   w_cap_rs1;
  logic [XLEN-1:0]   w_cap_rs2;

  assign w_adv = !r_vld || ex_rdy_i;

  assign w_rd_match = (id_use_rs1_i && (id_rs1_i == r_rd)) ||
                      (id_use_rs2_i && (id_rs2_i == r_rd));

  assign w_hazard = id_vld_i && r_vld && r_is_load && r_reg_wr &&
                    (r_rd != '0) && w_rd_match;

  assign id_rdy_o = flush_i || (w_adv && !w_hazard);

  // x0 is never a forwarding source, whichever stage claims to write it.
  assign w_mem_hit_rs1 = mem_reg_wr_i && (mem_rd_i != '0) && (mem_rd_i == r_rs1);
  assign w_mem_hit_rs2 = mem_reg_wr_i && (mem_rd_i != '0) && (mem_rd_i == r_rs2);
  assign w_wb_hit_rs1  = wb_reg_wr_i && (wb_rd_i != '0) && (wb_rd_i == r_rs1);
  assign w_wb_hit_rs2  = wb_reg_wr_i && (wb_rd_i != '0) && (wb_rd_i == r_rs2);

  assign w_fwd_rs1 = w_mem_hit_rs1 ? mem_rslt_i :
                     w_wb_hit_rs1  ? wb_rslt_i  : r_rs1_data;
  assign w_fwd_rs2 = w_mem_hit_rs2 ? mem_rslt_i :
                     w_wb_hit_rs2  ? wb_rslt_i  : r_rs2_data;

  // The register file write from WB lands this same edge, so its read data is stale.
  assign w_wb_hit_id_rs1 = wb_reg_wr_i && (wb_rd_i != '0) && (wb_rd_i == id_rs1_i);
  assign w_wb_hit_id_rs2 = wb_reg_wr_i && (wb_rd_i != '0) && (wb_rd_i == id_rs2_i);
  assign w_cap_rs1 = w_wb_hit_id_rs1 ? wb_rslt_i : id_rs1_data_i;
  assign w_cap_rs2 = w_wb_hit_id_rs2 ? wb_rslt_i : id_rs2_data_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_vld      <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_srcA_sel <= 1'b0;
      r_srcB_sel <= 1'b0;
      r_alu_ctrl <= '0;
      r_rd       <= '0;
      r_reg_wr   <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (flush_i) begin
      r_vld <= 1'b0;
    end else if (w_adv && w_hazard) begin
      r_vld <= 1'b0;
    end else if (w_adv) begin
      r_vld      <= id_vld_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rs1_data <= w_cap_rs1;
      r_rs2_data <= w_cap_rs2;
      r_imm      <= id_imm_i;
      r_pc       <= id_pc_i;
      r_srcA_sel <= id_srcA_sel_i;
      r_srcB_sel <= id_srcB_sel_i;
      r_alu_ctrl <= id_alu_ctrl_i;
      r_rd       <= id_rd_i;
      r_reg_wr   <= id_reg_wr_i;
      r_is_load  <= id_is_load_i;
    end else begin
      // Stalled with a valid instruction: absorb producers before they retire past WB.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end
  end

`ifdef RV32_IDEX_PERF_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_bubble_cnt <= '0;
    end else if (w_adv && w_hazard && !flush_i && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  assign ex_vld_o      = r_vld;
  assign ex_srcA_o     = r_srcA_sel ? r_pc  : w_fwd_rs1;
  assign ex_srcB_o     = r_srcB_sel ? r_imm : w_fwd_rs2;
  assign ex_rs2_o      = w_fwd_rs2;
  assign ex_alu_ctrl_o = r_vld ? r_alu_ctrl : 3'b000;
  assign ex_rd_o       = r_rd;
  assign ex_reg_wr_o   = r_vld && r_reg_wr;
  assign ex_is_load_o  = r_vld && r_is_load;

endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// tb/tb_rv32_id_ex_stage.sv - directed and randomized check of rv32_id_ex_stage against a behavioural model
module tb_rv32_id_ex_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic        id_vld, id_rdy;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_sa, id_sb;
  logic [2:0]  id_alu;
  logic        id_wr, id_ld, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_wr, wb_wr;
  logic [31:0] mem_rslt, wb_rslt;
  logic        ex_rdy, ex_vld;
  logic [31:0] ex_srcA, ex_srcB, ex_rs2;
  logic [2:0]  ex_alu;
  logic [4:0]  ex_rd;
  logic        ex_wr, ex_ld;
`ifdef RV32_IDEX_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model of the instruction held in the stage
  bit          m_vld;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  bit          m_sa, m_sb, m_wr, m_ld;
  logic [2:0]  m_alu;
  longint      m_bub;

  always #5 clk = ~clk;

  rv32_id_ex_stage dut (
    .clk_i(clk), .rstn_i(rstn),
    .id_vld_i(id_vld), .id_rdy_o(id_rdy),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_pc_i(id_pc),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_srcA_sel_i(id_sa), .id_srcB_sel_i(id_sb),
    .id_alu_ctrl_i(id_alu), .id_reg_wr_i(id_wr), .id_is_load_i(id_ld),
    .flush_i(flush),
    .mem_rd_i(mem_rd), .mem_reg_wr_i(mem_wr), .mem_rslt_i(mem_rslt),
    .wb_rd_i(wb_rd), .wb_reg_wr_i(wb_wr), .wb_rslt_i(wb_rslt),
    .ex_rdy_i(ex_rdy), .ex_vld_o(ex_vld),
    .ex_srcA_o(ex_srcA), .ex_srcB_o(ex_srcB), .ex_rs2_o(ex_rs2),
    .ex_alu_ctrl_o(ex_alu), .ex_rd_o(ex_rd), .ex_reg_wr_o(ex_wr),
`ifdef RV32_IDEX_PERF_EN
    .bubble_cnt_o(bubble_cnt),
`endif
    .ex_is_load_o(ex_ld)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Newest producer wins; a write to x0 carries no value.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held);
    if (r == 0) return held;
    if (mem_wr && mem_rd == r) return mem_rslt;
    if (wb_wr && wb_rd == r) return wb_rslt;
    return held;
  endfunction

  function automatic logic [31:0] regfile_read(input logic [4:0] r, input logic [31:0] rf);
    if (r != 0 && wb_wr && wb_rd == r) return wb_rslt;
    return rf;
  endfunction

  task automatic idle_inputs();
    id_vld = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_sa = 0; id_sb = 0; id_alu = 0; id_wr = 0; id_ld = 0; flush = 0;
    mem_rd = 0; mem_wr = 0; mem_rslt = 0; wb_rd = 0; wb_wr = 0; wb_rslt = 0;
    ex_rdy = 1;
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model with the edge.
  task automatic step();
    bit load_use, ex_free;
    @(negedge clk);
    load_use = id_vld && m_vld && m_ld && m_wr && m_rd != 0 &&
               ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    ex_free  = !m_vld || ex_rdy;
    check_eq("id_rdy", 32'(id_rdy), 32'(flush || (ex_free && !load_use)));
    check_eq("ex_vld", 32'(ex_vld), 32'(m_vld));
    check_eq("alu", 32'(ex_alu), m_vld ? 32'(m_alu) : 32'd0);
    check_eq("reg_wr", 32'(ex_wr), 32'(m_vld && m_wr));
    check_eq("is_load", 32'(ex_ld), 32'(m_vld && m_ld));
    if (m_vld) begin
      check_eq("srcA", ex_srcA, m_sa ? m_pc : newest(m_rs1, m_d1));
      check_eq("srcB", ex_srcB, m_sb ? m_imm : newest(m_rs2, m_d2));
      check_eq("rs2", ex_rs2, newest(m_rs2, m_d2));
      check_eq("rd", 32'(ex_rd), 32'(m_rd));
    end
`ifdef RV32_IDEX_PERF_EN
    check_eq("bubble_cnt", bubble_cnt, 32'(m_bub));
`endif
    if (!rstn) begin
      m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
      m_imm = 0; m_pc = 0; m_sa = 0; m_sb = 0; m_wr = 0; m_ld = 0; m_alu = 0; m_bub = 0;
    end else if (flush) begin
      m_vld = 0;
    end else if (ex_free && load_use) begin
      m_vld = 0;
      if (m_bub < 64'hFFFF_FFFF) m_bub++;
    end else if (ex_free) begin
      m_vld = id_vld; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = regfile_read(id_rs1, id_rs1_data); m_d2 = regfile_read(id_rs2, id_rs2_data);
      m_imm = id_imm; m_pc = id_pc; m_sa = id_sa; m_sb = id_sb;
      m_alu = id_alu; m_wr = id_wr; m_ld = id_ld;
    end else begin
      m_d1 = newest(m_rs1, m_d1);
      m_d2 = newest(m_rs2, m_d2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rd, input bit ld);
    idle_inputs();
    id_vld = 1; id_rs1 = rs1; id_rs1_data = d1; id_use_rs1 = 1;
    id_rd = rd; id_wr = 1; id_ld = ld;
    step();
  endtask

  task automatic randomize_inputs();
    rstn        = ($urandom_range(0, 99) != 0);
    id_vld      = ($urandom_range(0, 3) != 0);
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm      = $urandom; id_pc = $urandom;
    id_rs1      = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd       = 5'($urandom_range(0, 7));
    id_use_rs1  = ($urandom_range(0, 4) != 0); id_use_rs2 = ($urandom_range(0, 4) != 0);
    id_sa       = 1'($urandom); id_sb = 1'($urandom);
    id_alu      = 3'($urandom);
    id_wr       = ($urandom_range(0, 9) < 7); id_ld = ($urandom_range(0, 9) < 4);
    flush       = ($urandom_range(0, 11) == 0);
    mem_rd      = 5'($urandom_range(0, 7)); mem_wr = 1'($urandom); mem_rslt = $urandom;
    wb_rd       = 5'($urandom_range(0, 7)); wb_wr = 1'($urandom); wb_rslt = $urandom;
    ex_rdy      = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    step();
    step();
    rstn = 1;
    #1;
    check_eq("rst_vld", 32'(ex_vld), 0);
    check_eq("rst_srcA", ex_srcA, 0);
    check_eq("rst_srcB", ex_srcB, 0);
    check_eq("rst_rs2", ex_rs2, 0);
    check_eq("rst_alu", 32'(ex_alu), 0);
    check_eq("rst_rd", 32'(ex_rd), 0);
    check_eq("rst_wr_ld", {30'd0, ex_wr, ex_ld}, 0);

    // Basic capture: rs1 plus immediate
    idle_inputs();
    id_vld = 1; id_rs1 = 5; id_rs1_data = 32'h10; id_use_rs1 = 1; id_imm = 32'h4; id_sb = 1;
    step();
    idle_inputs();
    #1;
    check_eq("t1_vld", 32'(ex_vld), 1);
    check_eq("t1_srcA", ex_srcA, 32'h10);
    check_eq("t1_srcB", ex_srcB, 32'h4);
    rstn = 0;
    id_vld = 1;
    step();
    rstn = 1;
    idle_inputs();
    #1;
    check_eq("t1_rst_vld", 32'(ex_vld), 0);

    // MEM over WB, then WB alone, then x0 never forwarded
    issue(5'd3, 32'h1, 5'd12, 0);
    idle_inputs();
    ex_rdy = 0; mem_wr = 1; mem_rd = 3; mem_rslt = 32'hAA; wb_wr = 1; wb_rd = 3; wb_rslt = 32'hBB;
    #1;
    check_eq("fwd_mem", ex_srcA, 32'hAA);
    mem_rd = 0;
    #1;
    check_eq("fwd_wb", ex_srcA, 32'hBB);
    step();
    issue(5'd0, 32'h123, 5'd12, 0);
    idle_inputs();
    ex_rdy = 0; mem_wr = 1; mem_rd = 0; mem_rslt = 32'hDEAD;
    #1;
    check_eq("fwd_x0", ex_srcA, 32'h123);
    step();

    // Load-use on rs2: one bubble, then issue
    issue(5'd1, 32'h0, 5'd7, 1);
    idle_inputs();
    id_vld = 1; id_rs2 = 7; id_use_rs2 = 1; id_rd = 8; id_wr = 1;
    #1;
    check_eq("lu_rdy", 32'(id_rdy), 0);
    step();
    check_eq("lu_bubble", 32'(ex_vld), 0);
    check_eq("lu_rdy2", 32'(id_rdy), 1);
    step();
    check_eq("lu_issue", 32'(ex_vld), 1);
`ifdef RV32_IDEX_PERF_EN
    check_eq("lu_cnt", bubble_cnt, 1);
`endif

    // Flush with a valid instruction and a waiting decode instruction
    idle_inputs();
    id_vld = 1; id_rd = 9; id_wr = 1; flush = 1; ex_rdy = 0;
    #1;
    check_eq("fl_rdy", 32'(id_rdy), 1);
    step();
    idle_inputs();
    #1;
    check_eq("fl_vld", 32'(ex_vld), 0);
    check_eq("fl_wr", 32'(ex_wr), 0);

    // WB producer retires while EX stalls
    issue(5'd4, 32'h0, 5'd12, 0);
    idle_inputs();
    ex_rdy = 0; wb_wr = 1; wb_rd = 4; wb_rslt = 32'h55;
    step();
    wb_wr = 0; wb_rslt = 0;
    step();
    step();
    check_eq("stall_keep", ex_srcA, 32'h55);

    // Same-cycle register file write at capture
    idle_inputs();
    id_vld = 1; id_rs1 = 9; id_rs1_data = 0; id_use_rs1 = 1;
    wb_wr = 1; wb_rd = 9; wb_rslt = 32'h77;
    step();
    idle_inputs();
    #1;
    check_eq("wb_cap", ex_srcA, 32'h77);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
